fir_out_decim: RTL and testbench
================================

# fir_out_decim

Output stage directly downstream of the 30-tap fixed-point FIR. It takes one 16-bit sign-magnitude FIR output sample per strobe and converts it to two's complement. It averages each group of DECIM consecutive samples (accumulate-and-dump) and buffers the results in a small FIFO. A valid/ready interface delivers them to the consumer.

## Interface
- DECIM, 4: decimation ratio; power of two, 2..16
- FIFO_DEPTH, 8: output FIFO entries; power of two, 2..32
- clk_slow  in  1  sample-domain clock, same clock as the FIR
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe, FIR output sample present
- in_data  in  16  FIR output sample; [15] sign, [14:0] magnitude
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  16  decimated sample, two's complement
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held
- overflow  out  1  sticky; a result was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- **Conversion:** in_data → 16-bit two's complement.
  - sign=0 gives +mag; sign=1 gives −mag.
  - 0x8000 (negative zero) maps to 0.
  - Range is −32767..+32767.
- **Phase and accumulator:**
  - Phase counter runs 0..DECIM−1 and advances only on in_valid, wrapping to 0.
  - Accumulator width is 16+log2(DECIM), signed.
  - On in_valid with phase=0: acc ← sample.
  - Otherwise on in_valid: acc ← acc + sample.
- **Dump:** on in_valid with phase=DECIM−1:
  - avg = (acc + sample) >>> log2(DECIM), arithmetic shift, floor rounding.
  - avg is always within 16-bit range, so no saturation is needed.
  - avg is registered into dump_data with dump_valid=1 for one cycle.
- **FIFO push:**
  - A dump_valid cycle writes dump_data, unless the FIFO is full with no pop that cycle.
  - In that case the new value is dropped and overflow is set.
  - Existing entries are never overwritten.
- **FIFO pop:** out_valid && out_ready pops the head.
  - The FIFO is first-word-fall-through: out_data = head whenever out_valid=1.
  - out_data is 0 when the FIFO is empty.
- **Simultaneous push and pop:**
  - Allowed at any level, including full; level is unchanged and the push succeeds.
  - At empty this cannot occur, because out_valid=0.
- **Overflow flag:**
  - overflow stays set until clr_ovf=1.
  - If clr_ovf and an overflow event fall in the same cycle, set wins.
- **in_valid spacing:** in_valid may be asserted on consecutive cycles; the block sustains one sample per cycle.

## Timing
- **Reset (rst=0, asynchronous):**
  - phase=0, acc=0, dump_valid=0, FIFO emptied.
  - Outputs: out_valid=0, out_data=0, fifo_level=0, overflow=0.
  - Reset mid-group discards the partial accumulation.
  - Deassertion is synchronised externally; the first in_valid after reset is phase 0.
- **Latency:** the last sample of a group is sampled at edge N.
  - dump_valid is high in cycle N→N+1.
  - FIFO write happens at edge N+1.
  - out_valid=1 and out_data are valid after edge N+1.
  - Total: 2 clk_slow edges from the final input to output.
- **Level update:** fifo_level updates on the same edge as the push or pop.
- **Backpressure:** out_ready has no effect on input acceptance. in_valid is never stalled; backpressure only fills the FIFO.

## Structure
- **Shared package fir_pkg:**
  - SM_W=16.
  - Function sm_to_tc(input [15:0]) returning signed [15:0].
  - The FIR front end uses the same function for its coefficient convention.
- **Sub-module sync_fifo:**
  - Parameters WIDTH and DEPTH; one instance, WIDTH=16.
  - Read/write pointers with an extra wrap bit for full/empty, plus a level output.
  - Asynchronous active-low reset.
- **Top level:** conversion, phase counter, accumulator, dump register, overflow logic.

## Test plan
- **Basic average:** DECIM=4; in_data 0x0004, 0x8002, 0x0006, 0x0000 on consecutive cycles → sum 8, out_data=0x0002 with out_valid=1 two edges after the 4th sample.
- **Negative floor and negative zero:**
  - 0x8001 ×3, 0x8002 → sum −5, out_data=0xFFFE.
  - 0x8000 ×4 → out_data=0x0000.
- **Extremes:**
  - 0x7FFF ×4 → 0x7FFF.
  - 0xFFFF ×4 → 0x8001.
  - No wrap in the accumulator.
- **Backpressure and overflow:** out_ready=0, 9 full groups with FIFO_DEPTH=8.
  - fifo_level=8 and overflow=1 after the 9th dump.
  - Draining yields groups 1..8 in order.
  - clr_ovf clears overflow.
- **Push/pop at full:** FIFO full with out_ready=1 in the same cycle as dump_valid → push accepted, level stays 8, overflow stays 0.
- **Reset mid-group:** 2 samples of 0x0010, assert rst, then 4 samples of 0x0004 → single output 0x0004. FIFO empty and overflow=0 immediately after rst asserts.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample width and sign-magnitude to two's-complement conversion.
// Used by the FIR front end (coefficients) and by the output decimator (samples).
package fir_pkg;
    localparam int SM_W = 16;

    // Negative zero (sign set, magnitude 0) naturally maps to 0.
    function automatic logic signed [SM_W-1:0] sm_to_tc(input logic [SM_W-1:0] sm);
        logic signed [SM_W-1:0] mag;
        mag = $signed({1'b0, sm[SM_W-2:0]});
        return sm[SM_W-1] ? -mag : mag;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level output.
// Latency: write visible at output after the write edge.
// Backpressure: caller must not push when full unless also popping.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        // Same slot, opposite lap: the writer is a full lap ahead.
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = (pop && !empty) ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // At full with a simultaneous pop the write lands in the slot being read out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end
endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: sign-magnitude to two's complement, DECIM-sample average, output FIFO.
// Latency: 2 clk_slow edges from the last sample of a group to out_valid.
// Backpressure: input never stalls; a full FIFO drops the result and sets sticky overflow.
import fir_pkg::*;

module fir_out_decim #(
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_slow,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [SM_W-1:0]               in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SM_W-1:0]               out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_ovf
);
    localparam int SH    = $clog2(DECIM);
    localparam int ACC_W = SM_W + SH;
    localparam logic [SH-1:0] LAST_PH = SH'(DECIM - 1);

    logic [SH-1:0]           phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    dump_vld_q, dump_vld_d;
    logic [SM_W-1:0]         dump_dat_q, dump_dat_d;
    logic                    ovf_q, ovf_d;
    logic signed [SM_W-1:0]  sample;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] avg;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    always_comb begin
        sample     = sm_to_tc(in_data);
        sum        = {{SH{sample[SM_W-1]}}, sample};
        if (phase_q != '0) begin
            sum = acc_q + sum;
        end
        // Mean of DECIM 16-bit values always fits back in 16 bits.
        avg        = sum >>> SH;

        phase_d    = phase_q;
        acc_d      = acc_q;
        dump_vld_d = 1'b0;
        dump_dat_d = dump_dat_q;
        if (in_valid) begin
            acc_d = sum;
            if (phase_q == LAST_PH) begin
                phase_d    = '0;
                dump_vld_d = 1'b1;
                dump_dat_d = avg[SM_W-1:0];
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end

        pop   = out_valid && out_ready;
        push  = dump_vld_q && (!fifo_full || pop);
        ovf_d = (dump_vld_q && !push) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            phase_q    <= '0;
            acc_q      <= '0;
            dump_vld_q <= 1'b0;
            dump_dat_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            dump_vld_q <= dump_vld_d;
            dump_dat_q <= dump_dat_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (SM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_slow),
        .rst_n    (rst),
        .push     (push),
        .push_dat (dump_dat_q),
        .pop      (pop),
        .pop_dat  (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_fir_out_decim.sv
// Scoreboard bench for fir_out_decim with DECIM=4, FIFO_DEPTH=8.
module tb_fir_out_decim;
    localparam int D     = 4;
    localparam int DEPTH = 8;

    logic        clk_slow = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    fir_out_decim #(.DECIM(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk_slow   (clk_slow),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk_slow = ~clk_slow;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sm_val(input logic [15:0] x);
        int m;
        m = int'(x[14:0]);
        return x[15] ? -m : m;
    endfunction

    // Floor division by D done with an explicit non-negative remainder.
    function automatic logic [15:0] model_avg(input logic [15:0] a, b, c, d);
        int s, r, q;
        s = sm_val(a) + sm_val(b) + sm_val(c) + sm_val(d);
        r = ((s % D) + D) % D;
        q = (s - r) / D;
        return q[15:0];
    endfunction

    task automatic send_sample(input logic [15:0] x);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk_slow);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_group(input logic [15:0] a, b, c, d, input bit expect_push);
        if (expect_push) exp_q.push_back(model_avg(a, b, c, d));
        send_sample(a);
        send_sample(b);
        send_sample(c);
        send_sample(d);
    endtask

    task automatic step();
        @(posedge clk_slow);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) chk({tag, "_timeout"}, exp_q.size(), 0);
        step();
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_valid"}, out_valid, 0);
    endtask

    // Output side: a handshake seen mid-cycle completes at the next edge.
    initial begin
        forever begin
            @(negedge clk_slow);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", out_data, 16'hDEAD);
                else chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] r0, r1, r2, r3;

        repeat (3) @(posedge clk_slow);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b1;
        step();

        // Basic average and latency
        out_ready = 1'b1;
        send_group(16'h0004, 16'h8002, 16'h0006, 16'h0000, 1'b1);
        @(negedge clk_slow);
        chk("lat_edge_n", out_valid, 0);
        @(posedge clk_slow);
        @(negedge clk_slow);
        chk("lat_edge_n1", out_valid, 1);
        chk("lat_data", out_data, 16'h0002);
        #1;

        // Negative floor, negative zero, extremes, back-to-back
        send_group(16'h8001, 16'h8001, 16'h8001, 16'h8002, 1'b1);
        send_group(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
        send_group(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
        send_group(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int g = 0; g < 6; g++) begin
            r0 = 16'($urandom); r1 = 16'($urandom);
            r2 = 16'($urandom); r3 = 16'($urandom);
            send_group(r0, r1, r2, r3, 1'b1);
        end
        drain("stream");

        // Backpressure and overflow
        out_ready = 1'b0;
        for (int g = 1; g <= 8; g++) begin
            send_group(16'(g * 16), 16'(g * 16), 16'(g * 16), 16'(g * 16), 1'b1);
        end
        step();
        chk("fill8_level", fifo_level, 8);
        chk("fill8_ovf", overflow, 0);
        send_group(16'h0900, 16'h0900, 16'h0900, 16'h0900, 1'b0);
        step();
        chk("ovf_level", fifo_level, 8);
        chk("ovf_set", overflow, 1);
        step();
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);
        drain("ovf_drain");

        // Push and pop in the same cycle at full
        out_ready = 1'b0;
        for (int g = 1; g <= 8; g++) begin
            send_group(16'(g * 3), 16'(g * 3), 16'(g * 3), 16'(g * 3), 1'b1);
        end
        step();
        chk("pp_full", fifo_level, 8);
        send_group(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pp_level", fifo_level, 8);
        chk("pp_ovf", overflow, 0);
        drain("pp_drain");

        // Reset mid-group discards partial sum and FIFO contents
        out_ready = 1'b0;
        send_group(16'h0020, 16'h0020, 16'h0020, 16'h0020, 1'b0);
        step();
        chk("pre_rst_level", fifo_level, 1);
        send_sample(16'h0010);
        send_sample(16'h0010);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ovf", overflow, 0);
        step();
        rst = 1'b1;
        step();
        out_ready = 1'b1;
        send_group(16'h0004, 16'h0004, 16'h0004, 16'h0004, 1'b1);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
